// File: rtl/updn_counter_mod.sv
// updn_counter_mod: modulo-MODULUS up/down counter with synchronous load,
// terminal-count flags and a registered wrap pulse.
//
// Parameters:
//   WIDTH    counter width in bits (2..16)
//   MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (count=0, wrap=0)
//   en       count enable
//   dir      direction, 0 = up, 1 = down
//   load     synchronous load strobe (highest priority)
//   load_val load value, clipped to MODULUS-1
//   count    registered count
//   at_max   count == MODULUS-1
//   at_min   count == 0
//   tc       terminal count in the current direction
//   wrap     one-cycle pulse after a wrapping edge
// Build option:
//   UPDN_COUNTER_SAT_EN  saturate at the range ends instead of wrapping;
//                        wrap is then constant 0.

module updn_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             load_over;
    logic [WIDTH-1:0] load_clip;

    // MODULUS may equal 2**WIDTH, so compare in 32 bits.
    assign load_over = 32'(load_val) >= MODULUS;
    assign load_clip = load_over ? MAX_V : load_val;

    assign at_max = (count == MAX_V);
    assign at_min = (count == '0);
    assign tc     = dir ? at_min : at_max;

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clip;
        end else if (en) begin
            if (!dir) begin
                if (at_max) begin
`ifdef UPDN_COUNTER_SAT_EN
                    count_d = count;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count + ONE_V;
                end
            end else begin
                if (at_min) begin
`ifdef UPDN_COUNTER_SAT_EN
                    count_d = count;
`else
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end

endmodule
